// File: rtl/ft6206_defines.sv
// Shared FT6206 register map and touch-snapshot type, used by the I2C target
// and by ft6206_controller.
package ft6206_defines;

  localparam logic [7:0] TD_STATUS = 8'h02;
  localparam logic [7:0] P1_XH     = 8'h03;
  localparam logic [7:0] P1_XL     = 8'h04;
  localparam logic [7:0] P1_YH     = 8'h05;
  localparam logic [7:0] P1_YL     = 8'h06;
  localparam logic [7:0] CHIP_ID   = 8'hA3;
  localparam logic [7:0] VENDOR_ID = 8'hA8;

  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [8:0] y;
  } touch_t;

  // Register file seen by the initiator; the ID values come in as arguments
  // because they are parameters of the instantiating module.
  function automatic logic [7:0] reg_read(input logic [7:0] ptr, input touch_t t,
                                          input logic [7:0] chip_id,
                                          input logic [7:0] vendor_id);
    logic [7:0] r;
    r = 8'h00;
    case (ptr)
      TD_STATUS: r = {7'b0, t.valid};
      P1_XH:     r = {(t.valid ? 2'b10 : 2'b01), 5'b0, t.x[8]};
      P1_XL:     r = t.x[7:0];
      P1_YH:     r = {7'b0, t.y[8]};
      P1_YL:     r = t.y[7:0];
      CHIP_ID:   r = chip_id;
      VENDOR_ID: r = vendor_id;
      default:   r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronizes SCL/SDA into the clk domain and reports bus events as
// single-cycle pulses derived only from the synchronized samples.
module i2c_line_monitor (
  input  logic clk,
  input  logic rstb,
  input  logic scl,
  input  logic sda_in,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s
);
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // NOTE: every flop here resets to 1 so a reset looks like an idle bus and
  // cannot fabricate a START, STOP or SCL edge on release.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign start    = scl_q & scl_s &  sda_q & ~sda_s;
  assign stop     = scl_q & scl_s & ~sda_q &  sda_s;
  assign scl_rise = ~scl_q &  scl_s;
  assign scl_fall =  scl_q & ~scl_s;

endmodule

// File: rtl/ft6206_i2c_target.sv
// FT6206-compatible I2C target: register pointer writes and coherent
// touch-point reads, oversampling the bus with clk (>= 20x SCL).
module ft6206_i2c_target #(
  parameter logic [6:0] ADDRESS   = 7'h38,
  parameter logic [7:0] VENDOR_ID = 8'h11,
  parameter logic [7:0] CHIP_ID   = 8'h06
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       touch_valid,
  input  logic [8:0] touch_x,
  input  logic [8:0] touch_y,
  output logic       busy
);
  import ft6206_defines::touch_t;
  import ft6206_defines::reg_read;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t     state;
  logic [7:0] ptr;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       rw;
  logic       first_wr;
  touch_t     snap;
  logic [7:0] rd_byte;
  logic       start, stop, scl_rise, scl_fall, sda_s;

  i2c_line_monitor u_mon (
    .clk      (clk),
    .rstb     (rstb),
    .scl      (scl),
    .sda_in   (sda_in),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s)
  );

  assign rd_byte = reg_read(ptr, snap, CHIP_ID, VENDOR_ID);

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      ptr       <= 8'h00;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      first_wr  <= 1'b0;
      snap      <= '0;
    end else if (start) begin
      state     <= S_ADDR;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else if (stop) begin
      state     <= S_IDLE;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            shift     <= {shift[6:0], sda_s};
            bit_cnt   <= bit_cnt + 3'd1;
            byte_done <= (bit_cnt == 3'd7);
          end else if (scl_fall && byte_done) begin
            // Eighth bit finished: SCL is now low, so the ACK can go out.
            byte_done <= 1'b0;
            if (state == S_WR_DATA) begin
              sda_oe   <= 1'b1;
              state    <= S_WR_ACK;
              ptr      <= first_wr ? shift : ptr + 8'd1;
              first_wr <= 1'b0;
            end else if (shift[7:1] == ADDRESS) begin
              sda_oe   <= 1'b1;
              busy     <= 1'b1;
              rw       <= shift[0];
              first_wr <= 1'b1;
              state    <= S_ADDR_ACK;
              if (shift[0]) snap <= {touch_valid, touch_x, touch_y};
            end else begin
              state <= S_IGNORE;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 3'd0;
            state   <= S_WR_DATA;
          end
        end
        S_ADDR_ACK, S_RD_ACK: begin
          // In S_RD_ACK, byte_done records that the initiator ACKed.
          if (state == S_RD_ACK && scl_rise) begin
            if (sda_s) begin
              state <= S_IGNORE;
              busy  <= 1'b0;
            end else begin
              byte_done <= 1'b1;
            end
          end else if (scl_fall && (state == S_RD_ACK ? byte_done : 1'b1)) begin
            byte_done <= 1'b0;
            bit_cnt   <= 3'd0;
            if (state == S_ADDR_ACK && !rw) begin
              sda_oe <= 1'b0;
              state  <= S_WR_DATA;
            end else begin
              shift  <= rd_byte;
              ptr    <= ptr + 8'd1;
              sda_oe <= ~rd_byte[7];
              state  <= S_RD_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= S_RD_ACK;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {shift[6:0], 1'b0};
              sda_oe  <= ~shift[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ft6206_i2c_target.sv
// Bench for ft6206_i2c_target: bit-banged I2C initiator, a vector table, hand
// sequences for bus corner cases, and randomized reads against a register model.
module tb_ft6206_i2c_target;

  localparam int         Q    = 6;       // clk cycles per quarter SCL period
  localparam logic [6:0] ADDR = 7'h38;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       touch_valid = 1'b0;
  logic [8:0] touch_x = '0;
  logic [8:0] touch_y = '0;
  logic       sda_oe;
  logic       busy;
  wire        sda_line = sda_m & ~sda_oe;

  int         tests = 0;
  int         failed = 0;
  int         hi_changes = 0;
  int         oe_cycles = 0;
  int         busy_cycles = 0;
  logic       oe_prev = 1'b0;
  logic [7:0] model_ptr = 8'h00;

  always #5 clk = ~clk;

  ft6206_i2c_target dut (
    .clk         (clk),
    .rstb        (rstb),
    .scl         (scl),
    .sda_in      (sda_line),
    .sda_oe      (sda_oe),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .busy        (busy)
  );

  // Bus observer: the target must never move SDA while SCL is high.
  always @(negedge clk) begin
    if (rstb && scl && (sda_oe !== oe_prev)) hi_changes++;
    oe_prev = sda_oe;
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register map from the datasheet view, in plain arithmetic.
  function automatic int model_reg(input logic [7:0] a, input logic v, input int x, input int y);
    case (a)
      8'h02:   return int'(v);
      8'h03:   return (v ? 128 : 64) + x / 256;
      8'h04:   return x % 256;
      8'h05:   return y / 256;
      8'h06:   return y % 256;
      8'hA3:   return 8'h06;
      8'hA8:   return 8'h11;
      default: return 0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    tick(Q);
    scl   = 1'b1; tick(2 * Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    b     = sda_line; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(~ack);
  endtask

  task automatic set_ptr(input logic [7:0] p, input logic do_stop, input string tag);
    logic ack;
    bus_start();
    put_byte({ADDR, 1'b0}, ack);
    check({tag, " wr addr ack"}, ack, 1'b1);
    check({tag, " busy after addr ack"}, busy, 1'b1);
    put_byte(p, ack);
    check({tag, " ptr ack"}, ack, 1'b1);
    if (do_stop) bus_stop();
    model_ptr = p;
  endtask

  // Reads n bytes (last one NACKed); byte i lands in got[47-8*i -: 8].
  // When change_at >= 0, touch_x becomes new_x after that byte.
  task automatic read_bytes(input int n, input int change_at, input int new_x,
                            input string tag, output logic [47:0] got);
    logic       ack;
    logic [7:0] d;
    got = '0;
    bus_start();
    put_byte({ADDR, 1'b1}, ack);
    check({tag, " rd addr ack"}, ack, 1'b1);
    check({tag, " busy in read"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      get_byte(d, i != n - 1);
      got[47 - 8 * i -: 8] = d;
      if (i == change_at) touch_x = 9'(new_x);
    end
    check({tag, " busy after nack"}, busy, 1'b0);
    bus_stop();
    model_ptr = 8'(model_ptr + n);
  endtask

  typedef struct {
    logic       v;
    int         x;
    int         y;
    logic [7:0] ptr;
    logic       use_stop;
    int         n;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [47:0] got;
    logic        ack;
    logic        b;
    logic [7:0]  base;
    logic        v;
    int          x, y, n, oe0, busy0;

    vecs[0] = '{1'b1, 200, 300, 8'h03, 1'b0, 4, 48'h80C8_012C_0000};
    vecs[1] = '{1'b1, 10,  20,  8'hA3, 1'b1, 6, 48'h0600_0000_0011};
    vecs[2] = '{1'b0, 239, 319, 8'h02, 1'b1, 5, 48'h0040_EF01_3F00};
    vecs[3] = '{1'b1, 77,  256, 8'h05, 1'b0, 2, 48'h0100_0000_0000};
    vecs[4] = '{1'b1, 5,   7,   8'hFF, 1'b1, 2, 48'h0000_0000_0000};

    tick(4);
    check("reset sda_oe", sda_oe, 1'b0);
    check("reset busy", busy, 1'b0);
    rstb = 1'b1;
    tick(4);

    for (int k = 0; k < 5; k++) begin
      touch_valid = vecs[k].v;
      touch_x     = 9'(vecs[k].x);
      touch_y     = 9'(vecs[k].y);
      set_ptr(vecs[k].ptr, vecs[k].use_stop, $sformatf("vec%0d", k));
      read_bytes(vecs[k].n, -1, 0, $sformatf("vec%0d", k), got);
      for (int i = 0; i < vecs[k].n; i++)
        check($sformatf("vec%0d byte%0d", k, i), got[47 - 8 * i -: 8], vecs[k].exp[47 - 8 * i -: 8]);
    end

    // Pointer wrapped past 0xFF and now sits at 0x01: next bytes are reg 0x01, 0x02.
    read_bytes(2, -1, 0, "wrap follow", got);
    check("wrap follow reg01", got[47:40], 8'h00);
    check("wrap follow reg02", got[39:32], 8'h01);

    // Foreign address: no ACK, no SDA activity, not busy.
    oe0 = oe_cycles;
    busy0 = busy_cycles;
    bus_start();
    put_byte({7'h39, 1'b0}, ack);
    check("foreign addr ack", ack, 1'b0);
    put_byte(8'h02, ack);
    check("foreign data ack", ack, 1'b0);
    bus_stop();
    check("foreign sda_oe cycles", oe_cycles - oe0, 0);
    check("foreign busy cycles", busy_cycles - busy0, 0);

    // Snapshot coherence: touch_x changes after the first byte of the read.
    touch_valid = 1'b1;
    touch_x = 9'd10;
    touch_y = 9'd50;
    set_ptr(8'h02, 1'b1, "snap");
    read_bytes(3, 0, 20, "snap", got);
    check("snap reg02", got[47:40], 8'h01);
    check("snap reg03", got[39:32], 8'h80);
    check("snap reg04 old x", got[31:24], 8'd10);
    set_ptr(8'h04, 1'b1, "snap2");
    read_bytes(1, -1, 0, "snap2", got);
    check("snap2 reg04 new x", got[47:40], 8'd20);

    // Reset while the target holds SDA low for a 0 data bit (0xC8 bit 5).
    touch_x = 9'd200;
    set_ptr(8'h04, 1'b1, "rst");
    bus_start();
    put_byte({ADDR, 1'b1}, ack);
    check("rst rd addr ack", ack, 1'b1);
    get_bit(b);
    get_bit(b);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(1);
    check("rst target drives 0", sda_oe, 1'b1);
    #2 rstb = 1'b0;
    #1 check("rst async release", sda_oe, 1'b0);
    check("rst busy", busy, 1'b0);
    tick(2);
    rstb = 1'b1;
    scl = 1'b0; tick(Q);
    bus_stop();
    model_ptr = 8'h00;
    read_bytes(3, -1, 0, "post rst", got);
    check("post rst reg00", got[47:40], 8'h00);
    check("post rst reg01", got[39:32], 8'h00);
    check("post rst reg02", got[31:24], 8'h01);

    // Randomized traffic against the model.
    for (int it = 0; it < 12; it++) begin
      logic [7:0] p;
      int         mode;
      touch_valid = 1'($urandom_range(0, 1));
      touch_x     = 9'($urandom_range(0, 239));
      touch_y     = 9'($urandom_range(0, 319));
      case ($urandom_range(0, 8))
        0: p = 8'h00;  1: p = 8'h02;  2: p = 8'h03;  3: p = 8'h04;
        4: p = 8'h05;  5: p = 8'h06;  6: p = 8'hA3;  7: p = 8'hA8;
        default: p = 8'($urandom);
      endcase
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        set_ptr(p, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
      end else if (mode == 1) begin
        int extra;
        extra = int'($urandom_range(1, 3));
        set_ptr(p, 1'b0, $sformatf("rnd%0d", it));
        for (int e = 0; e < extra; e++) begin
          put_byte(8'($urandom), ack);
          check($sformatf("rnd%0d extra ack%0d", it, e), ack, 1'b1);
        end
        bus_stop();
        model_ptr = 8'(p + extra);
      end
      v = touch_valid;
      x = int'(touch_x);
      y = int'(touch_y);
      base = model_ptr;
      n = int'($urandom_range(1, 4));
      read_bytes(n, -1, 0, $sformatf("rnd%0d", it), got);
      for (int i = 0; i < n; i++)
        check($sformatf("rnd%0d reg%02h", it, 8'(base + i)), got[47 - 8 * i -: 8],
              model_reg(8'(base + i), v, x, y));
    end

    check("sda_oe changes while scl high", hi_changes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
